afu_irq_arbiter: RTL
====================

// Module: afu_irq_arbiter
// PURPOSE
// - Shares the single MSI-X request path to the PCIe host among NUM_AFUS x NUM_AFU_INTERRUPTS AFU interrupt vectors.
// - Latches per-vector pending bits, exposed as the PBA, and honours the host per-vector mask.
// - Round-robin selects one unmasked pending vector, issues it with a valid/ready handshake, then waits for host completion.
// - Sits between the AFU port interrupt sources and the PCIe MSI-X generator.
// PARAMETERS
// - NUM_AFUS            1     number of AFU ports
// - NUM_AFU_INTERRUPTS  7     vectors per AFU
// - NV                  NUM_AFUS*NUM_AFU_INTERRUPTS   total vectors (derived); flat idx = afu*NUM_AFU_INTERRUPTS+vec
// - ACK_TIMEOUT         1024  cycles to wait for msix_done (used only with OFS_IRQ_TIMEOUT_EN)
// PORTS
// - clk           in   1                       clock
// - rst           in   1                       async reset, active-high
// - irq_req       in   NV                      1-cycle request pulses, flat-indexed
// - irq_mask      in   NV                      1 = vector masked by host
// - irq_pending   out  NV                      pending bits (PBA)
// - irq_ack       out  NV                      1-cycle pulse when that vector's interrupt completes
// - msix_valid    out  1                       issue request to PCIe
// - msix_ready    in   1                       PCIe accepts request
// - msix_afu      out  max(1,$clog2(NUM_AFUS)) AFU number of the issued vector
// - msix_vector   out  $clog2(NUM_AFU_INTERRUPTS)  vector number within that AFU
// - msix_done     in   1                       1-cycle pulse: host write for the issued interrupt sent
// - err_timeout   out  1                       1-cycle pulse on completion timeout
// BEHAVIOUR
// - Reset values: all outputs 0; pending cleared; RR pointer 0; FSM in IDLE. Asynchronous reset mid-operation aborts any in-flight issue; no ack is generated.
// - Pending: irq_req[i] sets pending[i] at the next edge. Repeated requests on an already-pending bit merge into one interrupt.
// - Set vs clear: pending[i] clears on entry to ISSUE for i. A set and clear of the same bit in one cycle leaves it set.
// - FSM, IDLE: elig = pending & ~irq_mask. If elig != 0, pick the first set bit searching upward from ptr with wrap at NV-1 -> 0.
//   - Register sel, clear pending[sel], set ptr = (sel+1) mod NV, go to ISSUE.
// - FSM, ISSUE: msix_valid = 1 with msix_afu/msix_vector = sel/NUM_AFU_INTERRUPTS and sel%NUM_AFU_INTERRUPTS.
//   - Outputs stay stable until msix_ready. valid&ready -> go to WAIT_DONE and drop valid.
//   - A mask change after selection does not retract the request.
// - FSM, WAIT_DONE: on msix_done, pulse irq_ack[sel] and return to IDLE.
//   - msix_done outside WAIT_DONE is ignored.
//   - msix_done arriving in the same cycle as the WAIT_DONE entry edge is ignored.
// - Latency: irq_req at cycle N -> pending at N+1 -> msix_valid at N+2 (FSM idle, vector unmasked).
//   - Back-to-back issues are separated by at least 1 IDLE cycle.
// - A re-request of sel during ISSUE/WAIT_DONE sets pending again. That vector is issued again after completion, subject to RR order.
// - Masked pending bits hold indefinitely and are issued after unmask.
// CONFIGURATION
// - OFS_IRQ_TIMEOUT_EN defined: a counter runs in WAIT_DONE and resets on entry.
//   - If it reaches ACK_TIMEOUT-1 with no msix_done: pulse err_timeout, set pending[sel] again, go to IDLE.
//   - No irq_ack is generated in that case.
// - Not defined: WAIT_DONE waits indefinitely; err_timeout tied 0; no counter logic.
// TESTING
// - Issue timing: irq_req[3] at cycle 0, msix_ready=1 -> msix_valid at cycle 2 with afu=0, vector=3.
//   - msix_done at cycle 8 -> irq_ack[3] pulse at cycle 9; pending[3]=0.
// - RR order and wrap: irq_req[1,4,6] together -> issue order 1,4,6.
//   - Then irq_req[0,4] -> issue order 0,4 (pointer wrapped to 0).
// - Mask: irq_mask[2]=1, irq_req[2] -> pending[2]=1 and no msix_valid for 50 cycles.
//   - Clear mask -> vector 2 issued 1 cycle later.
// - Re-request in flight: irq_req[5] again during WAIT_DONE for 5 -> after msix_done, a second issue of vector 5 with one irq_ack per completion.
// - Timeout with OFS_IRQ_TIMEOUT_EN, ACK_TIMEOUT=16: no msix_done -> err_timeout pulse 16 cycles after WAIT_DONE entry; vector reissued.
//   - Without the macro: FSM holds in WAIT_DONE.
// - Reset: assert rst while in WAIT_DONE with pending[0,2] set -> all outputs 0, pending=0, no irq_ack.
//   - After release, a new irq_req[6] issues vector 6 (pointer 0).

Source files
------------

// File: rtl/afu_irq_arbiter.sv
// Round-robin arbiter sharing the MSI-X request path among all AFU interrupt vectors.
// Optional completion timeout is built when OFS_IRQ_TIMEOUT_EN is defined.
module afu_irq_arbiter #(
    parameter int NUM_AFUS           = 1,
    parameter int NUM_AFU_INTERRUPTS = 7,
    parameter int NV                 = NUM_AFUS * NUM_AFU_INTERRUPTS,
    parameter int ACK_TIMEOUT        = 1024,
    localparam int AFU_W = (NUM_AFUS > 1) ? $clog2(NUM_AFUS) : 1,
    localparam int VEC_W = (NUM_AFU_INTERRUPTS > 1) ? $clog2(NUM_AFU_INTERRUPTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NV-1:0]    irq_req,
    input  logic [NV-1:0]    irq_mask,
    output logic [NV-1:0]    irq_pending,
    output logic [NV-1:0]    irq_ack,
    output logic             msix_valid,
    input  logic             msix_ready,
    output logic [AFU_W-1:0] msix_afu,
    output logic [VEC_W-1:0] msix_vector,
    input  logic             msix_done,
    output logic             err_timeout
);

    localparam int          IDX_W = (NV > 1) ? $clog2(NV) : 1;
    localparam int unsigned NAI   = NUM_AFU_INTERRUPTS;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    logic [NV-1:0]    elig;
    logic [NV-1:0]    set_vec;
    logic [NV-1:0]    clr_vec;
    logic             timeout;

    // Two passes give the upward search from ptr with wrap to 0.
    always_comb begin
        elig  = irq_pending & ~irq_mask;
        pick  = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NV; j++) begin
            if (!found && elig[j] && (j >= 32'(ptr))) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NV; j++) begin
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        ptr_next = (pick == IDX_W'(NV - 1)) ? '0 : pick + IDX_W'(1);
        clr_vec  = (state == IDLE && found) ? (NV'(1) << pick) : '0;
        set_vec  = irq_req | (timeout ? (NV'(1) << sel) : '0);
    end

`ifdef OFS_IRQ_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == WAIT_DONE) && !msix_done && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout;
            if (state != WAIT_DONE) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            sel         <= '0;
            irq_pending <= '0;
            irq_ack     <= '0;
            msix_valid  <= 1'b0;
            msix_afu    <= '0;
            msix_vector <= '0;
        end else begin
            irq_ack     <= '0;
            // A new request wins over the clear taken on issue.
            irq_pending <= (irq_pending & ~clr_vec) | set_vec;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel         <= pick;
                        ptr         <= ptr_next;
                        msix_afu    <= AFU_W'(32'(pick) / NAI);
                        msix_vector <= VEC_W'(32'(pick) % NAI);
                        msix_valid  <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (msix_ready) begin
                        msix_valid <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (msix_done) begin
                        irq_ack <= NV'(1) << sel;
                        state   <= IDLE;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
